// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game blocks: state encoding of the
// sequence presenter and the widths of the ROM address, ROM data and timer.
package jogo_pkg;

    localparam int LARG_END   = 4;
    localparam int LARG_DADO  = 4;
    localparam int LARG_TEMPO = 12;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        FIM     = 4'd4
    } estado_t;

endpackage

// File: rtl/exibe_sequencia_if.sv
// Signal bundle between the sequence presenter and the rest of the game.
//
// Handshake: iniciar is a level request that the presenter accepts only
// while idle (db_estado == INICIAL); there is no ready, a request seen in any
// other state is dropped, and limite is captured on the accepting edge.
// Completion is reported by pronto, high for exactly one cycle, after which
// the presenter is idle again and may accept the next iniciar.
interface exibe_sequencia_if;

    logic                            iniciar;
    logic [jogo_pkg::LARG_END-1:0]   limite;
    logic [jogo_pkg::LARG_DADO-1:0]  dado_rom;
    logic [jogo_pkg::LARG_END-1:0]   endereco;
    logic [jogo_pkg::LARG_DADO-1:0]  leds;
    logic                            exibindo;
    logic                            pronto;
    logic [3:0]                      db_estado;

    // Presenter side
    modport slave (
        input  iniciar, limite, dado_rom,
        output endereco, leds, exibindo, pronto, db_estado
    );

    // Game controller / ROM side
    modport master (
        output iniciar, limite, dado_rom,
        input  endereco, leds, exibindo, pronto, db_estado
    );

endinterface

// File: rtl/exibe_sequencia_temporizador.sv
// Loadable down-counter used for both the LED on-time and the dark gap.
// It stops at zero; zero is a plain decode of the count.
module temporizador_exibe
    import jogo_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [LARG_TEMPO-1:0] valor,
    input  logic                  conta,
    output logic                  zero
);

    logic [LARG_TEMPO-1:0] contagem;

    // Count register: load has priority over decrementing
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else if (load) begin
            contagem <= valor;
        end else if (conta && (contagem != '0)) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign zero = (contagem == '0);

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence presenter: walks ROM entries 0..limite, lighting each on the LEDs
// for TEMPO_ACESO cycles followed by TEMPO_APAGADO dark cycles.
module exibe_sequencia
    import jogo_pkg::*;
#(
    parameter int TEMPO_ACESO   = 500,
    parameter int TEMPO_APAGADO = 250
) (
    input  logic               clock,
    input  logic               reset,
    exibe_sequencia_if.slave   bus
);

    // Timer reload values are one less than the length: the timer hits zero
    // in the last cycle of the interval.
    localparam logic [LARG_TEMPO-1:0] VALOR_ACESO   = LARG_TEMPO'(TEMPO_ACESO - 1);
    localparam logic [LARG_TEMPO-1:0] VALOR_APAGADO = LARG_TEMPO'(TEMPO_APAGADO - 1);

    estado_t               estado;
    estado_t               prox_estado;
    logic [LARG_END-1:0]   endereco;
    logic [LARG_END-1:0]   limite_reg;
    logic                  captura;
    logic                  incrementa;
    logic                  t_load;
    logic                  t_conta;
    logic [LARG_TEMPO-1:0] t_valor;
    logic                  t_zero;

    temporizador_exibe u_temporizador (
        .clock (clock),
        .reset (reset),
        .load  (t_load),
        .valor (t_valor),
        .conta (t_conta),
        .zero  (t_zero)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state and datapath control
    always_comb begin
        prox_estado = estado;
        captura     = 1'b0;
        incrementa  = 1'b0;
        t_load      = 1'b0;
        t_conta     = 1'b0;
        t_valor     = '0;
        case (estado)
            INICIAL: begin
                if (bus.iniciar) begin
                    captura     = 1'b1;
                    prox_estado = PREPARA;
                end
            end
            PREPARA: begin
                // One cycle so the ROM output catches up with endereco
                t_load      = 1'b1;
                t_valor     = VALOR_ACESO;
                prox_estado = ACENDE;
            end
            ACENDE: begin
                if (t_zero) begin
                    t_load      = 1'b1;
                    t_valor     = VALOR_APAGADO;
                    prox_estado = APAGA;
                end else begin
                    t_conta = 1'b1;
                end
            end
            APAGA: begin
                if (t_zero) begin
                    if (endereco == limite_reg) begin
                        prox_estado = FIM;
                    end else begin
                        incrementa  = 1'b1;
                        prox_estado = PREPARA;
                    end
                end else begin
                    t_conta = 1'b1;
                end
            end
            FIM: begin
                prox_estado = INICIAL;
            end
            default: begin
                prox_estado = INICIAL;
            end
        endcase
    end

    // Address and captured-limit registers
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco   <= '0;
            limite_reg <= '0;
        end else if (captura) begin
            endereco   <= '0;
            limite_reg <= bus.limite;
        end else if (incrementa) begin
            endereco <= endereco + 1'b1;
        end
    end

    assign bus.endereco  = endereco;
    assign bus.leds      = (estado == ACENDE) ? bus.dado_rom : '0;
    assign bus.exibindo  = (estado != INICIAL) && (estado != FIM);
    assign bus.pronto    = (estado == FIM);
    assign bus.db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: random runs against a cycle-timeline model of
// the presentation, checked through an expected-output queue.
module tb_exibe_sequencia;
    import jogo_pkg::*;

    localparam int TA = 4;
    localparam int TG = 2;
    localparam int P  = 1 + TA + TG;

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] endereco;
        logic       exibindo;
        logic       pronto;
        logic [3:0] estado;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    bit         mon_on = 1'b0;
    logic [3:0] idle_end = 4'd0;
    int         prontos_vistos = 0;
    int         prontos_esperados = 0;
    logic [3:0] rom [16];

    exibe_sequencia_if bus ();

    exibe_sequencia #(
        .TEMPO_ACESO   (TA),
        .TEMPO_APAGADO (TG)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- ROM model: 1-cycle latency ----------------
    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'(i + 1);
    end

    always @(posedge clock) bus.dado_rom <= rom[bus.endereco];

    // ---------------- reference model ----------------
    // Expected outputs for cycles 1..(lim+1)*P+1 after the accepting edge.
    function automatic void model_run(input logic [3:0] lim);
        int   n;
        int   k;
        int   r;
        exp_t e;
        n = int'(lim) + 1;
        for (int c = 1; c <= n * P; c++) begin
            k = (c - 1) / P;
            r = (c - 1) % P;
            e.endereco = 4'(k);
            e.exibindo = 1'b1;
            e.pronto   = 1'b0;
            if (r == 0) begin
                e.leds   = 4'd0;
                e.estado = 4'd1;
            end else if (r <= TA) begin
                e.leds   = 4'(k + 1);
                e.estado = 4'd2;
            end else begin
                e.leds   = 4'd0;
                e.estado = 4'd3;
            end
            exp_q.push_back(e);
        end
        e.leds     = 4'd0;
        e.endereco = lim;
        e.exibindo = 1'b0;
        e.pronto   = 1'b1;
        e.estado   = 4'd4;
        exp_q.push_back(e);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic iniciar_run(input logic [3:0] lim);
        bus.limite  = lim;
        bus.iniciar = 1'b1;
        @(posedge clock);
        model_run(lim);
        prontos_esperados++;
        idle_end = lim;
        #1;
        bus.iniciar = 1'b0;
        bus.limite  = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL wait_done: run still pending after %0d cycles, %0d entries left, required 0",
                     n, exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        exp_t a;
        exp_t e;
        if (mon_on) begin
            a.leds     = bus.leds;
            a.endereco = bus.endereco;
            a.exibindo = bus.exibindo;
            a.pronto   = bus.pronto;
            a.estado   = bus.db_estado;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
            end else begin
                e.leds     = 4'd0;
                e.endereco = idle_end;
                e.exibindo = 1'b0;
                e.pronto   = 1'b0;
                e.estado   = 4'd0;
            end
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs @%0t: leds=%h end=%h exib=%b pronto=%b est=%h, required leds=%h end=%h exib=%b pronto=%b est=%h",
                         $time, a.leds, a.endereco, a.exibindo, a.pronto, a.estado,
                         e.leds, e.endereco, e.exibindo, e.pronto, e.estado);
            end
            if (a.pronto === 1'b1) prontos_vistos++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        bus.iniciar = 1'b0;
        bus.limite  = 4'd0;
        @(posedge clock);
        #1;
        mon_on = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(3);

        // Directed: single entry, four entries, full ROM
        iniciar_run(4'd0);
        wait_done();
        iniciar_run(4'd3);
        wait_done();
        iniciar_run(4'd15);
        wait_done();

        // Re-pulse iniciar during ACENDE and move limite mid-run
        iniciar_run(4'd6);
        idle(2);
        bus.iniciar = 1'b1;
        bus.limite  = 4'd12;
        idle(1);
        bus.iniciar = 1'b0;
        idle(10);
        bus.limite  = 4'd1;
        wait_done();

        // Reset during the dark gap of entry 2 (cycle 20 after the start edge)
        iniciar_run(4'd5);
        repeat (19) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        exp_q.delete();
        prontos_esperados--;
        idle_end = 4'd0;
        #1;
        reset = 1'b0;
        idle(3);
        iniciar_run(4'd2);
        wait_done();

        // Random runs with random gaps and stray start requests
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 5));
            iniciar_run(4'($urandom_range(0, 15)));
            idle($urandom_range(1, 6));
            bus.iniciar = 1'($urandom_range(0, 1));
            bus.limite  = 4'($urandom_range(0, 15));
            idle(1);
            bus.iniciar = 1'b0;
            wait_done();
        end
        idle(4);
        mon_on = 1'b0;

        checks++;
        if (prontos_vistos != prontos_esperados) begin
            failures++;
            $display("FAIL pronto_count: saw %0d pulses, required %0d",
                     prontos_vistos, prontos_esperados);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
